sccb_init_sequencer: RTL

SCCB_INIT_SEQUENCER -- requirements
Module: sccb_init_sequencer

---
 rtl/sccb_init_sequencer_pkg.sv | 30 +++
 rtl/sccb_init_rom.sv | 51 +++++
 rtl/sccb_init_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sccb_init_sequencer_pkg.sv
// Shared definitions for the SCCB camera init sequencer and its register table.
package sccb_init_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PWRUP  = 4'd1,
    ST_SETTLE = 4'd2,
    ST_FETCH  = 4'd3,
    ST_DECODE = 4'd4,
    ST_ISSUE  = 4'd5,
    ST_WAIT   = 4'd6,
    ST_DELAY  = 4'd7,
    ST_DONE   = 4'd8,
    ST_FAULT  = 4'd9
  } state_t;

  localparam logic [15:0] END_MARK       = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK     = 16'hFFF0;
  localparam logic [7:0]  DEFAULT_CAM_ID = 8'h42;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// OV7670 register table: {sub_addr, value} entries, synchronous read, one cycle latency.
module sccb_init_rom
  import sccb_init_sequencer_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [15:0]   data
);

  logic [15:0] data_q, data_d;

  always_comb begin
    data_d = END_MARK;
    case (32'(addr))
      0:  data_d = 16'h1280;   // COM7: soft reset, needs the delay that follows
      1:  data_d = DELAY_MARK;
      2:  data_d = 16'h1204;   // COM7: RGB output
      3:  data_d = 16'h1100;   // CLKRC
      4:  data_d = 16'h0C00;
      5:  data_d = 16'h3E00;
      6:  data_d = 16'h40D0;   // COM15: RGB565
      7:  data_d = 16'h8C00;
      8:  data_d = 16'h3A04;
      9:  data_d = 16'h1438;
      10: data_d = 16'h4FB3;
      11: data_d = 16'h50B3;
      12: data_d = 16'h5100;
      13: data_d = 16'h523D;
      14: data_d = 16'h53A7;
      15: data_d = 16'h54E4;
      16: data_d = 16'h589E;
      17: data_d = 16'h3DC0;
      18: data_d = 16'h1711;
      19: data_d = 16'h1861;
      20: data_d = 16'h32A4;
      21: data_d = 16'h1903;
      22: data_d = 16'h1A7B;
      23: data_d = 16'h030A;
      default: data_d = END_MARK;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/sccb_init_sequencer.sv
// Camera power-up and register-table walker driving an SCCB transaction core.
// Handshake: sccb_start is a one-cycle request; sccb_done is a one-cycle completion honoured only in WAIT.
module sccb_init_sequencer
  import sccb_init_sequencer_pkg::*;
#(
  parameter logic [7:0] CAM_ID         = DEFAULT_CAM_ID,
  parameter int         ROM_AW         = 8,
  parameter int         RST_CYCLES     = 10000,
  parameter int         SETTLE_CYCLES  = 100000,
  parameter int         DELAY_CYCLES   = 100000,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              init_go,
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic              cam_pwdn,
  output logic              cam_rstn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_id_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data,
  input  logic              sccb_done,
  output logic [3:0]        dbg_state
);

  localparam int CNT_MAX = max4(RST_CYCLES, SETTLE_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST   = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              init_done_q, init_done_d;
  logic              init_err_q, init_err_d;
  logic [7:0]        id_q, id_d;
  logic [7:0]        sub_q, sub_d;
  logic [7:0]        data_q, data_d;
  logic              cam_pwdn_q, cam_pwdn_d;
  logic              cam_rstn_q, cam_rstn_d;
  logic              advance;
  logic              timed;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    id_d        = id_q;
    sub_d       = sub_q;
    data_d      = data_q;
    cam_pwdn_d  = cam_pwdn_q;
    cam_rstn_d  = cam_rstn_q;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (init_go) begin
          state_d     = ST_PWRUP;
          init_done_d = 1'b0;
          init_err_d  = 1'b0;
          rom_addr_d  = '0;
          cam_pwdn_d  = 1'b0;
          cam_rstn_d  = 1'b0;
        end
      end
      ST_PWRUP: begin
        if (cnt_q == RST_LAST) begin
          state_d    = ST_SETTLE;
          cam_rstn_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (rom_data == END_MARK) begin
          state_d     = ST_DONE;
          init_done_d = 1'b1;
        end else if (rom_data == DELAY_MARK) begin
          state_d = ST_DELAY;
        end else begin
          sub_d   = rom_data[15:8];
          data_d  = rom_data[7:0];
          id_d    = {CAM_ID[7:1], 1'b0};
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Done in the final counted cycle still wins over the timeout.
        if (sccb_done) begin
          advance = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d    = ST_FAULT;
          init_err_d = 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The last table slot terminates the walk instead of wrapping to entry 0.
    if (advance) begin
      if (rom_addr_q == ADDR_LAST) begin
        state_d     = ST_DONE;
        init_done_d = 1'b1;
      end else begin
        rom_addr_d = rom_addr_q + ROM_AW'(1);
        state_d    = ST_FETCH;
      end
    end
  end

  assign timed = state_q inside {ST_PWRUP, ST_SETTLE, ST_WAIT, ST_DELAY};

  always_comb begin
    cnt_d = '0;
    if (timed && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      id_q        <= 8'h00;
      sub_q       <= 8'h00;
      data_q      <= 8'h00;
      cam_pwdn_q  <= 1'b1;
      cam_rstn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      id_q        <= id_d;
      sub_q       <= sub_d;
      data_q      <= data_d;
      cam_pwdn_q  <= cam_pwdn_d;
      cam_rstn_q  <= cam_rstn_d;
    end
  end

  assign busy          = !(state_q inside {ST_IDLE, ST_DONE, ST_FAULT});
  assign init_done     = init_done_q;
  assign init_err      = init_err_q;
  assign cam_pwdn      = cam_pwdn_q;
  assign cam_rstn      = cam_rstn_q;
  assign rom_addr      = rom_addr_q;
  assign sccb_start    = (state_q == ST_ISSUE);
  assign sccb_id_addr  = id_q;
  assign sccb_sub_addr = sub_q;
  assign sccb_data     = data_q;
  assign dbg_state     = state_q;

endmodule
